// File: rtl/mmio_console.sv
// Memory-mapped console/exit agent: byte TX FIFO drained on a valid/ready stream,
// a sticky exit-code latch, FIFO status and a free-running cycle counter.
module mmio_console #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] host_to_agent,
  output logic [31:0] agent_to_host,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        exit_valid,
  output logic [31:0] exit_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_cycles;
  logic [31:0]   r_exit_code;
  logic          r_exit_valid;
  logic [31:0]   r_rdata;
  logic          r_rdvalid;

  logic [1:0]    w_reg;
  logic          w_empty;
  logic          w_full;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_count8;
  logic [31:0]   w_rdata;

  assign w_reg    = address[3:2];
  assign w_empty  = (r_count == CW'(0));
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_count8 = 8'(r_count);

  // Full-stall is purely combinational; a same-cycle pop does not release it.
  assign waitrequest = write && (w_reg == 2'd0) && w_full;
  assign w_wr_acc    = write && !waitrequest;
  assign w_rd_acc    = read && !write;
  assign w_push      = w_wr_acc && (w_reg == 2'd0) && byteenable[0];
  assign w_pop       = !w_empty && tx_ready;

  assign tx_valid      = !w_empty;
  assign tx_data       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign agent_to_host = r_rdata;
  assign readdatavalid = r_rdvalid;
  assign exit_valid    = r_exit_valid;
  assign exit_code     = r_exit_code;

  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_reg)
      2'd0:    w_rdata = 32'h0000_0000;
      2'd1:    w_rdata = {16'h0000, w_count8, 6'b00_0000, w_full, w_empty};
      2'd2:    w_rdata = r_exit_code;
      2'd3:    w_rdata = r_cycles;
      default: w_rdata = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_to_agent[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data reflects pre-edge state; a write in the same cycle drops the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdvalid <= 1'b0;
      r_rdata   <= 32'h0000_0000;
    end else begin
      r_rdvalid <= w_rd_acc;
      r_rdata   <= w_rd_acc ? w_rdata : 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles     <= 32'h0000_0000;
      r_exit_valid <= 1'b0;
      r_exit_code  <= 32'h0000_0000;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_wr_acc && (w_reg == 2'd2) && !r_exit_valid) begin
        r_exit_valid <= 1'b1;
        r_exit_code  <= host_to_agent;
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Randomized and directed bench for mmio_console against a queue-based model
// of the console register map, FIFO stream and exit latch.
module tb_mmio_console;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        readdatavalid;
  logic        waitrequest;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        exit_valid;
  logic [31:0] exit_code;

  mmio_console #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .host_to_agent(host_to_agent),
    .agent_to_host(agent_to_host), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .exit_valid(exit_valid), .exit_code(exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  q[$];
  logic [7:0]  sink[$];
  logic        m_exit;
  logic [31:0] m_code;
  logic [31:0] m_cyc;
  logic        last_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(q.size());
    return {16'h0000, cnt, 6'b00_0000, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_exit = 1'b0;
    m_code = 32'h0;
    m_cyc  = 32'h0;
  endfunction

  // One bus cycle: called just after a falling edge, returns at the next one.
  task automatic step(input logic rd, input logic wr, input logic [3:0] ad,
                      input logic [3:0] be, input logic [31:0] d, input logic rdy);
    logic        exp_wq;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        do_pop;
    logic [7:0]  b;
    read = rd; write = wr; address = ad; byteenable = be;
    host_to_agent = d; tx_ready = rdy;
    #1;
    exp_wq = wr && (ad[3:2] == 2'd0) && (q.size() == DEPTH);
    check_eq("waitrequest", {31'h0, waitrequest}, {31'h0, exp_wq});
    check_eq("tx_valid", {31'h0, tx_valid}, {31'h0, (q.size() != 0)});
    if (q.size() != 0) check_eq("tx_data", {24'h0, tx_data}, {24'h0, q[0]});
    exp_rv = rd && !wr;
    case (ad[3:2])
      2'd1:    exp_rd = model_status();
      2'd2:    exp_rd = m_code;
      2'd3:    exp_rd = m_cyc;
      default: exp_rd = 32'h0;
    endcase
    last_stall = exp_wq;
    @(posedge clk);
    do_pop = (q.size() != 0) && rdy;
    if (do_pop) begin
      b = q.pop_front();
      sink.push_back(b);
    end
    if (wr && !exp_wq && (ad[3:2] == 2'd0) && be[0]) q.push_back(d[7:0]);
    if (wr && !exp_wq && (ad[3:2] == 2'd2) && !m_exit) begin
      m_exit = 1'b1;
      m_code = d;
    end
    m_cyc = m_cyc + 32'd1;
    #1;
    check_eq("readdatavalid", {31'h0, readdatavalid}, {31'h0, exp_rv});
    if (exp_rv) check_eq("readdata", agent_to_host, exp_rd);
    check_eq("exit_valid", {31'h0, exit_valid}, {31'h0, m_exit});
    check_eq("exit_code", exit_code, m_code);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdata"}, agent_to_host, 32'h0);
    check_eq({tag, "_rdv"}, {31'h0, readdatavalid}, 32'h0);
    check_eq({tag, "_wait"}, {31'h0, waitrequest}, 32'h0);
    check_eq({tag, "_txv"}, {31'h0, tx_valid}, 32'h0);
    check_eq({tag, "_txd"}, {24'h0, tx_data}, 32'h0);
    check_eq({tag, "_exv"}, {31'h0, exit_valid}, 32'h0);
    check_eq({tag, "_exc"}, exit_code, 32'h0);
  endtask

  initial begin
    logic        r_rd, r_wr, r_rdy;
    logic [3:0]  r_ad, r_be;
    logic [31:0] r_d;

    rst = 1'b0; read = 1'b0; write = 1'b0; address = 4'h0;
    byteenable = 4'h0; host_to_agent = 32'h0; tx_ready = 1'b0;
    model_reset();
    last_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b1;

    // Idle 10 cycles, then CYCLES read returns 10.
    idle(10, 1'b0);
    check_all_zero("idle");
    step(1'b1, 1'b0, 4'hC, 4'h0, 32'h0, 1'b0);
    check_eq("cycles_at_10", agent_to_host, 32'd10);

    // Three bytes streamed in order.
    step(1'b0, 1'b1, 4'h0, 4'hF, 32'h41, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'hF, 32'h42, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'hF, 32'h43, 1'b1);
    idle(3, 1'b1);
    check_eq("sink_count", sink.size(), 32'd3);
    if (sink.size() == 3) begin
      check_eq("sink0", {24'h0, sink[0]}, 32'h41);
      check_eq("sink1", {24'h0, sink[1]}, 32'h42);
      check_eq("sink2", {24'h0, sink[2]}, 32'h43);
    end
    step(1'b1, 1'b0, 4'h4, 4'h0, 32'h0, 1'b0);
    check_eq("status_empty", agent_to_host, 32'h0000_0001);

    // Fill to 16, stall the 17th, release with one tx_ready cycle.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'h0, 4'h1, 32'h60 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 4'h5, 4'h0, 32'h0, 1'b0);
    check_eq("status_full", agent_to_host, 32'h0000_1002);
    step(1'b0, 1'b1, 4'h2, 4'hF, 32'h77, 1'b0);
    check_eq("stall_seen", {31'h0, last_stall}, 32'h1);
    step(1'b0, 1'b1, 4'h2, 4'hF, 32'h77, 1'b1);
    step(1'b0, 1'b1, 4'h2, 4'hF, 32'h77, 1'b0);
    check_eq("stall_released", {31'h0, last_stall}, 32'h0);
    step(1'b1, 1'b0, 4'h4, 4'h0, 32'h0, 1'b0);
    check_eq("status_refull", agent_to_host, 32'h0000_1002);

    // Exit latch keeps the first value.
    step(1'b0, 1'b1, 4'h8, 4'h0, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, 4'hA, 4'hF, 32'h1234_5678, 1'b0);
    step(1'b1, 1'b0, 4'h8, 4'h0, 32'h0, 1'b0);
    check_eq("exit_read", agent_to_host, 32'hDEAD_BEEF);
    check_eq("exit_code_pin", exit_code, 32'hDEAD_BEEF);

    // Reset mid-stall while a read result is still on the bus.
    read = 1'b0; write = 1'b1; address = 4'h0; byteenable = 4'hF;
    host_to_agent = 32'h99; tx_ready = 1'b0;
    #1;
    check_eq("pre_rst_wait", {31'h0, waitrequest}, 32'h1);
    check_eq("pre_rst_rdv", {31'h0, readdatavalid}, 32'h1);
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    write = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h4, 4'h0, 32'h0, 1'b0);
    check_eq("status_after_rst", agent_to_host, 32'h0000_0001);

    // Masked lane-0 write is discarded; read+write performs only the write.
    step(1'b0, 1'b1, 4'h0, 4'hE, 32'h55, 1'b0);
    step(1'b1, 1'b0, 4'h4, 4'h0, 32'h0, 1'b0);
    check_eq("status_no_push", agent_to_host, 32'h0000_0001);
    step(1'b1, 1'b1, 4'h0, 4'h1, 32'h5A, 1'b0);
    check_eq("rw_no_rdv", {31'h0, readdatavalid}, 32'h0);
    check_eq("rw_pushed", {31'h0, tx_valid}, 32'h1);

    // Randomized traffic; a stalled write is held until accepted.
    r_rd = 1'b0; r_wr = 1'b0; r_ad = 4'h0; r_be = 4'h0; r_d = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r_wr = ($urandom_range(0, 99) < 55);
        r_rd = ($urandom_range(0, 99) < 40);
        r_ad = ($urandom_range(0, 99) < 60) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        r_be = 4'($urandom_range(0, 15));
        r_d  = $urandom();
      end
      r_rdy = ($urandom_range(0, 99) < 35);
      step(r_rd, r_wr, r_ad, r_be, r_d, r_rdy);
    end
    idle(DEPTH + 2, 1'b1);
    check_eq("drained", {31'h0, tx_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_console.md
# mmio_console

Memory-mapped console/exit peripheral on the CPU data bus (Avalon-MM agent, placed beside the data memory behind the address decoder). Buffers bytes the program writes to a TX register in a FIFO and drains them on a valid/ready stream toward the bench's character sink. Latches a program-supplied exit code for the bench to end the simulation on. Exposes FIFO status and a free-running cycle counter for software.

## Interface
Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- address  in  4  byte offset within the block; bits [3:2] select the register, bits [1:0] are ignored.
- read  in  1  Avalon-MM read request.
- write  in  1  Avalon-MM write request.
- byteenable  in  4  write byte lanes.
- host_to_agent  in  32  write data.
- agent_to_host  out  32  read data; valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse carrying read data.
- waitrequest  out  1  stall; request held by host while 1.
- tx_valid  out  1  FIFO head byte available.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts head byte.
- exit_valid  out  1  sticky; program has written EXIT.
- exit_code  out  32  latched exit value.

## Operation
- Register map (address[3:2]):
  - 0 TXDATA (W): push host_to_agent[7:0] if byteenable[0]=1; if byteenable[0]=0, write is accepted and discarded. Reads return 0.
  - 1 STATUS (R): bit0 = empty, bit1 = full, bits[15:8] = occupancy count, zero-extended; other bits 0. Writes are ignored.
  - 2 EXIT (W): first accepted write latches all 32 bits into exit_code and sets exit_valid. Later writes are ignored until reset; byteenable is ignored. Reads return exit_code.
  - 3 CYCLES (R): 32-bit counter, +1 every cycle out of reset, wraps 0xFFFFFFFF -> 0. Writes are ignored.
- read and write asserted together: write is performed, read is dropped, no readdatavalid.
- FIFO: circular buffer with a log2(FIFO_DEPTH)+1 bit count.
  - tx_valid = !empty; tx_data = head entry.
  - Pop when tx_valid && tx_ready.
- Push and pop in the same cycle (not full): count unchanged, both take effect.
- Empty: tx_valid=0. tx_ready is ignored; the count never underflows.
- Full: waitrequest = write && address[3:2]==0 && full. This is combinational and does not consider a same-cycle pop.
  - A stalled write completes in the first cycle after full deasserts.
- waitrequest is never asserted for any other access.

## Timing
- Writes: accepted in the cycle write=1 and waitrequest=0; state updates at that rising edge.
- Reads: fixed latency 1. Accepted in cycle N (read=1, write=0); readdatavalid=1 and agent_to_host valid in cycle N+1 only.
- Read data reflects state before edge N:
  - STATUS reflects occupancy before the same-cycle push/pop.
  - CYCLES returns the counter value in cycle N.
- Back-to-back reads are supported: one result per cycle.
- Pushed byte: visible on tx_data/tx_valid the cycle after acceptance when the FIFO was empty.
- Popped entry: removed at the edge; the next entry is presented the following cycle.
- Reset (rst=0, asynchronous, any time, including mid-stall or mid-read):
  - FIFO emptied; tx_valid=0, tx_data=0.
  - readdatavalid=0, agent_to_host=0, waitrequest=0.
  - exit_valid=0, exit_code=0; cycle counter 0.
  - A read accepted just before reset produces no readdatavalid.
- Outputs are registered except waitrequest, tx_valid and tx_data, which are derived from registered state.

## Test plan
- Reset then idle 10 cycles: all outputs 0. Read CYCLES at cycle 10 after reset release -> readdatavalid next cycle with value 10.
- Write TXDATA 0x41, 0x42, 0x43 with tx_ready=1 -> sink receives 0x41, 0x42, 0x43 in order; STATUS afterwards reads 0x00000001.
- tx_ready=0, DEPTH=16: 16 writes accepted, STATUS = 0x00001002, 17th write sees waitrequest=1. Raise tx_ready for one cycle -> 17th write completes the next cycle and count stays 16.
- Write EXIT 0xDEADBEEF then 0x12345678 -> exit_valid=1, exit_code=0xDEADBEEF; read EXIT returns 0xDEADBEEF.
- TXDATA write with byteenable=4'b1110 -> no push, no waitrequest, STATUS stays 0x00000001. Simultaneous read+write of TXDATA -> push occurs, no readdatavalid.
- Assert rst=0 mid-stall with 16 entries and exit latched -> outputs 0 immediately; after release, STATUS reads 0x00000001.
